// File: rtl/par_ser_pkg.sv
// ============================================================================
// Module      : par_ser_pkg
// Description : Shared sizes and FSM state encoding for the parallel-to-serial
//               transmitter. PAR state present only with PAR_SER_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package par_ser_pkg;

    localparam int WORD_W  = 4;
    localparam int N_WORDS = 4;
    localparam int FRAME_W = WORD_W * N_WORDS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        SHIFT = 3'd2,
`ifdef PAR_SER_TX_PARITY_EN
        PAR   = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/piso_reg.sv
// ============================================================================
// Module      : piso_reg
// Description : Parallel-load, MSB-first shift register for one frame word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_sr;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr <= {r_sr[WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_sr[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/par_ser_tx.sv
// ============================================================================
// Module      : par_ser_tx
// Description : Sends words A..D as a 16-bit MSB-first serial frame preceded by
//               a SYNC strobe. Define PAR_SER_TX_PARITY_EN for an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module par_ser_tx
    import par_ser_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic [WORD_W-1:0] C,
    input  logic [WORD_W-1:0] D,
    output logic              data_TX,
    output logic              transmit,
    output logic [1:0]        Qbit,
    output logic [1:0]        Qwrd,
    output logic              busy,
    output logic              done
);

`ifdef PAR_SER_TX_PARITY_EN
    localparam state_t c_after_shift = PAR;
`else
    localparam state_t c_after_shift = DONE;
`endif

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_qbit;
    logic [1:0]         r_qwrd;
    logic [1:0]         w_nbit;
    logic [1:0]         w_nwrd;
    logic               w_load;
    logic               w_next_bit;
    logic               r_data_tx;
    logic               r_transmit;
    logic               r_busy;
    logic               r_done;
    logic [WORD_W-1:0]  w_words [N_WORDS];
    logic [N_WORDS-1:0] w_msb;
    logic [N_WORDS-1:0] w_shift;

    assign w_words[0] = A;
    assign w_words[1] = B;
    assign w_words[2] = C;
    assign w_words[3] = D;

    // Each word shifts on the edge that registers its current MSB onto data_TX.
    generate
        for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_word
            assign w_shift[gi] = (w_next == SHIFT) && (w_nwrd == 2'(gi));
            piso_reg #(.WIDTH(WORD_W)) u_piso (
                .clk     (clk),
                .clr     (clr),
                .i_load  (w_load),
                .i_shift (w_shift[gi]),
                .i_data  (w_words[gi]),
                .o_msb   (w_msb[gi])
            );
        end
    endgenerate

`ifdef PAR_SER_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^{A, B, C, D};
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        w_nbit = 2'd0;
        w_nwrd = 2'd0;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = SYNC;
                end
            end
            SYNC: w_next = SHIFT;
            SHIFT: begin
                if (r_qbit == 2'd3 && r_qwrd == 2'd3) begin
                    w_next = c_after_shift;
                end else begin
                    {w_nwrd, w_nbit} = {r_qwrd, r_qbit} + 4'd1;
                end
            end
`ifdef PAR_SER_TX_PARITY_EN
            PAR:  w_next = DONE;
`endif
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_next_bit = 1'b0;
        if (w_next == SHIFT) begin
            w_next_bit = w_msb[w_nwrd];
        end
`ifdef PAR_SER_TX_PARITY_EN
        if (w_next == PAR) begin
            w_next_bit = r_parity;
        end
`endif
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= IDLE;
            r_qbit     <= 2'd0;
            r_qwrd     <= 2'd0;
            r_data_tx  <= 1'b0;
            r_transmit <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_qbit     <= w_nbit;
            r_qwrd     <= w_nwrd;
            r_data_tx  <= w_next_bit;
            r_transmit <= (w_next == SYNC);
            r_busy     <= (w_next != IDLE);
            r_done     <= (w_next == DONE);
        end
    end

    assign data_TX  = r_data_tx;
    assign transmit = r_transmit;
    assign Qbit     = r_qbit;
    assign Qwrd     = r_qwrd;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: doc/par_ser_tx.md
PAR_SER_TX -- requirements
Module: par_ser_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all other ports are listed below.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to send one frame; sampled only in IDLE.
REQ-005 A, B, C, D  input  4 each  parallel words to send, in the order A, B, C, D.
REQ-006 data_TX  output  1  serial data line, which feeds the downstream receiver's data_RX.
REQ-007 transmit  output  1  one-cycle frame-start strobe to the receiver.
REQ-008 Qbit, Qwrd  output  2 each  bit index and word index of the bit currently on data_TX.
REQ-009 busy  output  1  high from frame acceptance through DONE.
REQ-010 done  output  1  one-cycle pulse when the frame is complete.

Function
REQ-011 The FSM SHALL have the states IDLE, SYNC, SHIFT, PAR (PAR exists only with PARITY_EN) and DONE.
REQ-012 In IDLE, when start=1 at edge k, the block SHALL snapshot A..D into a 16-bit frame register and enter SYNC at edge k+1.
REQ-013 In SYNC (exactly 1 cycle), outputs SHALL be: transmit=1, data_TX=0, busy=1.
REQ-014 SHIFT SHALL last exactly 16 cycles, with one bit driven per cycle.
REQ-015 SHIFT bit order SHALL be word A first, then B, C, D; within each word, bit 3 first.
REQ-016 The first SHIFT cycle SHALL present A[3], with Qwrd=0 and Qbit=0.
REQ-017 Qbit SHALL increment 0..3 and wrap to 0. Qwrd SHALL increment when Qbit wraps.
REQ-018 The SHIFT-to-next-state transition SHALL occur when Qbit=3 and Qwrd=3, in the same cycle as that bit.
REQ-019 DONE (1 cycle) SHALL drive done=1 and busy=1, and SHALL then return to IDLE.
REQ-020 The next start SHALL be accepted no earlier than the first IDLE cycle after DONE. The minimum frame period SHALL be 19 cycles (20 with parity).
REQ-021 start outside IDLE SHALL be ignored; it is neither queued nor causes a restart.
REQ-022 Changes on A..D after acceptance SHALL NOT affect the frame in flight.
REQ-023 Outside SHIFT/PAR, data_TX SHALL be 0. Outside SHIFT, Qbit and Qwrd SHALL be 0.
REQ-024 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-025 When start is held high continuously, back-to-back frames SHALL be sent, each separated by one IDLE cycle.

Reset
REQ-026 While clr=1, on the next clock edge, the state SHALL go to IDLE, and the frame register, Qbit, Qwrd, data_TX, transmit, busy and done SHALL all be 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, with no done pulse.
REQ-028 clr SHALL take priority over start in the same cycle.

Configuration
REQ-029 Macro PAR_SER_TX_PARITY_EN SHALL control the parity feature.
REQ-030 When PAR_SER_TX_PARITY_EN is defined, PAR SHALL be inserted after SHIFT for 1 cycle and drive data_TX = XOR of all 16 frame bits (even parity), with Qbit=0 and Qwrd=0.
REQ-031 When PAR_SER_TX_PARITY_EN is not defined, the PAR state and its logic SHALL be absent, and SHIFT SHALL go directly to DONE.

Structure
REQ-032 Package par_ser_pkg SHALL hold WORD_W=4, N_WORDS=4, FRAME_W=16 and the FSM state enumeration.
REQ-033 Sub-module piso_reg (4-bit parallel-load, MSB-first shift register) SHALL be instantiated once per word, with load in IDLE-accept and shift enabled for the active word only.
REQ-034 The bit/word counters SHALL be local 2-bit counters in par_ser_tx.

Verification
REQ-035 Basic frame: A=4'hA, B=4'h5, C=4'hF, D=4'h0, start pulsed 1 cycle -> transmit=1 at k+1; data_TX over the 16 SHIFT cycles is 1010 0101 1111 0000; done=1 at k+18.
REQ-036 Snapshot: after acceptance, change A to 4'h3 during SHIFT -> the serial stream still carries 4'hA.
REQ-037 Busy start: pulse start at SHIFT cycle 5 -> no new SYNC; exactly one done; next transmit only after the next IDLE start.
REQ-038 Reset mid-frame: assert clr during SHIFT cycle 9 -> next cycle all outputs are 0, state IDLE, no done; a following start sends a full frame.
REQ-039 Loopback: connect to the receiver (clk shared, clr_n = ~clr), send 16'h1234 -> receiver holds A=1, B=2, C=3, D=4 after done.
REQ-040 Parity (macro defined): A..D = 4'h7, 4'h0, 4'h0, 4'h0 -> PAR cycle data_TX=1, done at k+19; with A..D = 4'h3, 4'h0, 4'h0, 4'h0 -> parity bit 0.
